// File: rtl/dma_xfer_striper.sv
// ============================================================================
// dma_xfer_striper : splits one DMA descriptor into fixed-size chunks issued
// round-robin across parallel transfer channels; one irq per descriptor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_xfer_striper #(
  parameter int NUM_CHAN    = 4,
  parameter int SRC_AW      = 48,
  parameter int DST_AW      = 48,
  parameter int LEN_W       = 32,
  parameter int CHUNK_BYTES = 4096,
  parameter int CNT_W       = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [SRC_AW-1:0]          desc_src,
  input  logic [DST_AW-1:0]          desc_dst,
  input  logic [LEN_W-1:0]           desc_len,
  input  logic                       desc_fence,
  output logic [NUM_CHAN-1:0]        chan_valid,
  input  logic [NUM_CHAN-1:0]        chan_ready,
  output logic [NUM_CHAN*SRC_AW-1:0] chan_src,
  output logic [NUM_CHAN*DST_AW-1:0] chan_dst,
  output logic [NUM_CHAN*LEN_W-1:0]  chan_len,
  input  logic [NUM_CHAN-1:0]        chan_done,
  output logic                       fence_valid,
  input  logic                       fence_ready,
  output logic                       irq,
  output logic                       busy,
  output logic                       err
);

  localparam int RR_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int PC_W = $clog2(NUM_CHAN + 1);
  localparam logic [LEN_W-1:0] CHUNK_LEN = LEN_W'(CHUNK_BYTES);
  localparam logic [RR_W-1:0]  RR_LAST   = RR_W'(NUM_CHAN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPLIT = 3'd1,
    S_WAIT  = 3'd2,
    S_FENCE = 3'd3,
    S_IRQ   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SRC_AW-1:0] cur_src;
  logic [DST_AW-1:0] cur_dst;
  logic [LEN_W-1:0]  remaining;
  logic              fence_req;
  logic [RR_W-1:0]   rr;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  done_cnt;
  logic              err_q;

  logic              accept;
  logic              issue;
  logic              counting;
  logic              slot_free;
  logic [LEN_W-1:0]  chunk_len;
  logic [PC_W-1:0]   done_inc;
  logic [CNT_W:0]    done_sum;
  logic              done_over;
  logic [CNT_W-1:0]  done_sat;
  logic              all_done;

  always_comb begin
    done_inc = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      done_inc = done_inc + PC_W'(chan_done[i]);
    end
  end

  // A slot counts as free if it is empty or is being drained this very cycle.
  assign slot_free = !chan_valid[rr] || chan_ready[rr];
  assign chunk_len = (remaining > CHUNK_LEN) ? CHUNK_LEN : remaining;
  assign done_sum  = {1'b0, done_cnt} + (CNT_W+1)'(done_inc);
  assign done_over = done_sum > {1'b0, issued};
  assign done_sat  = done_over ? issued : done_sum[CNT_W-1:0];
  assign all_done  = (done_sat == issued);
  assign busy      = (state != S_IDLE);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    desc_ready  = 1'b0;
    fence_valid = 1'b0;
    irq         = 1'b0;
    issue       = 1'b0;
    accept      = 1'b0;
    counting    = 1'b0;
    case (state)
      S_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          accept     = 1'b1;
          state_next = S_SPLIT;
        end
      end
      S_SPLIT: begin
        counting = 1'b1;
        if (remaining == '0) begin
          state_next = S_WAIT;
        end else if (slot_free) begin
          issue = 1'b1;
        end
      end
      S_WAIT: begin
        // Uses the post-update done count so irq follows the last pulse by one cycle.
        counting = 1'b1;
        if ((chan_valid == '0) && all_done) begin
          state_next = fence_req ? S_FENCE : S_IRQ;
        end
      end
      S_FENCE: begin
        counting    = 1'b1;
        fence_valid = 1'b1;
        if (fence_ready) begin
          state_next = S_IRQ;
        end
      end
      S_IRQ: begin
        irq        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      fence_req <= 1'b0;
      rr        <= '0;
      issued    <= '0;
      done_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cur_src   <= desc_src;
        cur_dst   <= desc_dst;
        remaining <= desc_len;
        fence_req <= desc_fence;
        rr        <= '0;
        issued    <= '0;
        done_cnt  <= '0;
      end else if (issue) begin
        cur_src   <= cur_src + SRC_AW'(chunk_len);
        cur_dst   <= cur_dst + DST_AW'(chunk_len);
        remaining <= remaining - chunk_len;
        issued    <= issued + CNT_W'(1);
        rr        <= (rr == RR_LAST) ? '0 : rr + RR_W'(1);
      end
      if (counting) begin
        done_cnt <= done_sat;
        if (done_over) begin
          err_q <= 1'b1;
        end
      end else if (|chan_done) begin
        err_q <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      logic              load;
      logic              v_q;
      logic [SRC_AW-1:0] s_q;
      logic [DST_AW-1:0] d_q;
      logic [LEN_W-1:0]  l_q;

      assign load = issue && (rr == RR_W'(i));

      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= 1'b0;
          s_q <= '0;
          d_q <= '0;
          l_q <= '0;
        end else if (load) begin
          v_q <= 1'b1;
          s_q <= cur_src;
          d_q <= cur_dst;
          l_q <= chunk_len;
        end else if (chan_ready[i]) begin
          v_q <= 1'b0;
        end
      end

      assign chan_valid[i]                  = v_q;
      assign chan_src[i*SRC_AW +: SRC_AW]   = s_q;
      assign chan_dst[i*DST_AW +: DST_AW]   = d_q;
      assign chan_len[i*LEN_W +: LEN_W]     = l_q;
    end
  endgenerate

endmodule

`default_nettype wire
